mul_div_unit: RTL and testbench

Iterative RV32M multiply/divide unit in the execute stage, alongside the single-cycle ALU. When the main decoder sees op = 0110011 with funct7 = 0000001, it raises `start` with funct3 and the two operands. The unit runs a fixed-latency shift-add or restoring-divide sequence and returns one 32-bit result with a `done` pulse. The hazard unit stalls the pipeline on `busy`.

---
 rtl/mdu_pkg.sv | 37 +++
 rtl/mdu_sign_fix.sv | 35 +++
 rtl/mul_div_unit.sv | 162 ++++++++++++++++
 tb/tb_mul_div_unit.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared types and helpers for the RV32M multiply/divide unit.
package mdu_pkg;

    typedef enum logic [2:0] {
        MUL    = 3'b000,
        MULH   = 3'b001,
        MULHSU = 3'b010,
        MULHU  = 3'b011,
        DIV    = 3'b100,
        DIVU   = 3'b101,
        REM    = 3'b110,
        REMU   = 3'b111
    } mdu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } mdu_state_t;

    localparam logic [6:0] MDU_FUNCT7 = 7'b0000001;

    // rs1 is treated as signed for these operations
    function automatic logic op_signed_a(input mdu_op_t op);
        return op inside {MUL, MULH, MULHSU, DIV, REM};
    endfunction

    // rs2 is treated as signed for these operations
    function automatic logic op_signed_b(input mdu_op_t op);
        return op inside {MUL, MULH, DIV, REM};
    endfunction

    function automatic logic op_is_div(input mdu_op_t op);
        return op inside {DIV, DIVU, REM, REMU};
    endfunction

endpackage

// File: rtl/mdu_sign_fix.sv
// Final sign correction and result select, including divide-by-zero override.
module mdu_sign_fix
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  mdu_op_t            op_i,
    input  logic               sign_a_i,
    input  logic               sign_b_i,
    input  logic               div_zero_i,
    input  logic [WIDTH-1:0]   src_a_i,
    input  logic [2*WIDTH-1:0] acc_i,
    output logic [WIDTH-1:0]   result_c_o
);

    logic [2*WIDTH-1:0] prod_c;
    logic [WIDTH-1:0]   quo_c;
    logic [WIDTH-1:0]   rem_c;

    // Negate magnitudes back to signed values and pick the requested word
    always_comb begin
        prod_c     = (sign_a_i ^ sign_b_i) ? -acc_i : acc_i;
        quo_c      = (sign_a_i ^ sign_b_i) ? -acc_i[WIDTH-1:0] : acc_i[WIDTH-1:0];
        rem_c      = sign_a_i ? -acc_i[2*WIDTH-1:WIDTH] : acc_i[2*WIDTH-1:WIDTH];
        result_c_o = prod_c[WIDTH-1:0];
        case (op_i)
            MUL:                 result_c_o = prod_c[WIDTH-1:0];
            MULH, MULHSU, MULHU: result_c_o = prod_c[2*WIDTH-1:WIDTH];
            DIV, DIVU:           result_c_o = div_zero_i ? '1 : quo_c;
            REM, REMU:           result_c_o = div_zero_i ? src_a_i : rem_c;
            default:             ;
        endcase
    end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit: 32 iterations, done 33 cycles after accept.
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             flush,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int unsigned ACC_W = 2 * WIDTH;
    localparam int unsigned CNT_W = 6;

    mdu_state_t       state_q, state_d;
    mdu_op_t          op_q, op_d;
    logic             sign_a_q, sign_a_d;
    logic             sign_b_q, sign_b_d;
    logic             div_zero_q, div_zero_d;
    logic [WIDTH-1:0] a_raw_q, a_raw_d;
    logic [WIDTH-1:0] a_mag_q, a_mag_d;
    logic [WIDTH-1:0] b_mag_q, b_mag_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] result_q, result_d;

    logic             accept_c;
    mdu_op_t          start_op_c;
    logic [WIDTH:0]   mul_sum_c;
    logic [WIDTH:0]   div_trial_c;
    logic             div_ge_c;
    logic [WIDTH-1:0] div_rem_c;
    logic [ACC_W-1:0] step_acc_c;
    logic [WIDTH-1:0] fix_result_c;

    assign start_op_c = mdu_op_t'(funct3);
    assign accept_c   = start && !flush && (state_q == IDLE || state_q == DONE);

    // One iteration: multiply adds a_mag into the high half and shifts right,
    // divide shifts the next dividend bit into the remainder and trial-subtracts.
    always_comb begin
        mul_sum_c   = {1'b0, acc_q[ACC_W-1:WIDTH]} + {1'b0, a_mag_q & {WIDTH{b_mag_q[0]}}};
        div_trial_c = {acc_q[ACC_W-1:WIDTH], a_mag_q[WIDTH-1]};
        div_ge_c    = div_trial_c >= {1'b0, b_mag_q};
        div_rem_c   = div_ge_c ? WIDTH'(div_trial_c - {1'b0, b_mag_q}) : div_trial_c[WIDTH-1:0];
        if (op_is_div(op_q)) begin
            step_acc_c = {div_rem_c, acc_q[WIDTH-2:0], div_ge_c};
        end else begin
            step_acc_c = {mul_sum_c, acc_q[WIDTH-1:1]};
        end
    end

    // Sign correction sees the accumulator value produced by the final step
    mdu_sign_fix #(
        .WIDTH(WIDTH)
    ) u_sign_fix (
        .op_i      (op_q),
        .sign_a_i  (sign_a_q),
        .sign_b_i  (sign_b_q),
        .div_zero_i(div_zero_q),
        .src_a_i   (a_raw_q),
        .acc_i     (step_acc_c),
        .result_c_o(fix_result_c)
    );

    // Next-state: flush wins, then accept, then iterate; DONE falls back to IDLE
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        sign_a_d   = sign_a_q;
        sign_b_d   = sign_b_q;
        div_zero_d = div_zero_q;
        a_raw_d    = a_raw_q;
        a_mag_d    = a_mag_q;
        b_mag_d    = b_mag_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        result_d   = result_q;
        busy_d     = 1'b0;
        done_d     = 1'b0;

        if (flush) begin
            state_d = IDLE;
        end else if (accept_c) begin
            state_d    = BUSY;
            busy_d     = 1'b1;
            op_d       = start_op_c;
            sign_a_d   = op_signed_a(start_op_c) & src_a[WIDTH-1];
            sign_b_d   = op_signed_b(start_op_c) & src_b[WIDTH-1];
            a_mag_d    = sign_a_d ? -src_a : src_a;
            b_mag_d    = sign_b_d ? -src_b : src_b;
            a_raw_d    = src_a;
            div_zero_d = (src_b == '0);
            acc_d      = '0;
            cnt_d      = '0;
        end else if (state_q == BUSY) begin
            acc_d = step_acc_c;
            cnt_d = cnt_q + CNT_W'(1);
            if (op_is_div(op_q)) begin
                a_mag_d = a_mag_q << 1;
            end else begin
                b_mag_d = b_mag_q >> 1;
            end
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
                state_d  = DONE;
                done_d   = 1'b1;
                result_d = fix_result_c;
            end else begin
                busy_d = 1'b1;
            end
        end else begin
            state_d = IDLE;
        end
    end

    // State, datapath and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            op_q       <= MUL;
            sign_a_q   <= 1'b0;
            sign_b_q   <= 1'b0;
            div_zero_q <= 1'b0;
            a_raw_q    <= '0;
            a_mag_q    <= '0;
            b_mag_q    <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            result_q   <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            sign_a_q   <= sign_a_d;
            sign_b_q   <= sign_b_d;
            div_zero_q <= div_zero_d;
            a_raw_q    <= a_raw_d;
            a_mag_q    <= a_mag_d;
            b_mag_q    <= b_mag_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            result_q   <= result_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: reference arithmetic plus cycle timing model.
module tb_mul_div_unit;

    localparam int unsigned W = 32;
    localparam int LAT = 33;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         start;
    logic         flush;
    logic [2:0]   funct3;
    logic [W-1:0] src_a;
    logic [W-1:0] src_b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;

    int           checks = 0;
    int           errors = 0;

    int           cyc = 0;
    int           pend = -1;
    logic [31:0]  pend_val = 32'h0;
    logic [31:0]  exp_result = 32'h0;

    mul_div_unit #(.WIDTH(W)) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .start  (start),
        .flush  (flush),
        .funct3 (funct3),
        .src_a  (src_a),
        .src_b  (src_b),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    // RV32M semantics computed with plain 64-bit arithmetic
    function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] sa, sb, ua, ub, p;
        logic        ovf;
        sa  = {{32{a[31]}}, a};
        sb  = {{32{b[31]}}, b};
        ua  = {32'h0, a};
        ub  = {32'h0, b};
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return 32'h8000_0000;
                return $signed(a) / $signed(b);
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'h0;
                return $signed(a) % $signed(b);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic logic model_busy(input int c);
        return (pend >= 0) && (c >= pend - (LAT - 1)) && (c < pend);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Timing model: an accepted start yields busy for 32 cycles then a done pulse
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend       = -1;
            exp_result = 32'h0;
        end else begin
            if (flush) begin
                if (pend >= 0 && cyc < pend) pend = -1;
            end else if (start && !model_busy(cyc)) begin
                pend     = cyc + LAT;
                pend_val = ref_op(funct3, src_a, src_b);
            end
            cyc++;
            if (cyc == pend) exp_result = pend_val;
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        logic eb, ed;
        eb = model_busy(cyc);
        ed = (pend >= 0) && (cyc == pend);
        check("busy", 32'(busy), 32'(eb));
        check("done", 32'(done), 32'(ed));
        if (!eb) check("result", result, exp_result);
    end

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'h1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        start  = 1'b1;
        funct3 = f;
        src_a  = a;
        src_b  = b;
    endtask

    // Called in the cycle start is driven; returns in the done cycle
    task automatic wait_done(input string name, input logic [31:0] e, input int pulse_at);
        int lat;
        @(posedge clk); #1;
        start = 1'b0;
        lat   = 1;
        while (done !== 1'b1 && lat < 40) begin
            if (lat == pulse_at) begin
                issue(3'b100, $urandom, $urandom);
            end
            @(posedge clk); #1;
            start = 1'b0;
            lat++;
        end
        check({name, "_done"}, 32'(done), 32'h1);
        check({name, "_lat"}, 32'(lat), 32'(LAT));
        check({name, "_res"}, result, e);
    endtask

    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] e, input string name);
        @(posedge clk); #1;
        issue(f, a, b);
        wait_done(name, e, 0);
    endtask

    initial begin
        logic saw;
        reset_n = 1'b0;
        start   = 1'b0;
        flush   = 1'b0;
        funct3  = 3'b000;
        src_a   = '0;
        src_b   = '0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_result", result, 32'h0);
        reset_n = 1'b1;

        repeat (50) begin
            @(posedge clk); #1;
            check("idle_busy", 32'(busy), 32'h0);
            check("idle_done", 32'(done), 32'h0);
            check("idle_result", result, 32'h0);
        end

        run_op(3'b000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, "mul");
        run_op(3'b001, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, "mulh");
        run_op(3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu");
        run_op(3'b010, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu");
        run_op(3'b100, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, "div");
        run_op(3'b110, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, "rem");
        run_op(3'b101, 32'hFFFF_FFF9,  32'd2,         32'h7FFF_FFFC, "divu");
        run_op(3'b111, 32'hFFFF_FFF9,  32'd2,         32'h0000_0001, "remu");
        run_op(3'b100, 32'd5,          32'd0,         32'hFFFF_FFFF, "div_by0");
        run_op(3'b110, 32'hFFFF_FFFB,  32'd0,         32'hFFFF_FFFB, "rem_by0");
        run_op(3'b101, 32'd5,          32'd0,         32'hFFFF_FFFF, "divu_by0");
        run_op(3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, "div_ovf");
        run_op(3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, "rem_ovf");

        // start pulsed mid-operation is ignored
        @(posedge clk); #1;
        issue(3'b000, 32'd7, 32'hFFFF_FFFD);
        wait_done("busy_start", 32'hFFFF_FFEB, 5);

        // start in the done cycle: back-to-back
        run_op(3'b101, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, "b2b_first");
        issue(3'b111, 32'hFFFF_FFF9, 32'd2);
        wait_done("b2b_second", 32'h0000_0001, 0);

        // start together with flush while idle
        repeat (2) @(posedge clk);
        #1;
        issue(3'b000, 32'd3, 32'd3);
        flush = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        flush = 1'b0;
        check("sf_busy", 32'(busy), 32'h0);
        saw = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) saw = 1'b1;
        end
        check("sf_no_done", 32'(saw), 32'h0);
        check("sf_result", result, 32'h0000_0001);

        // flush 10 cycles into an operation
        @(posedge clk); #1;
        issue(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_busy", 32'(busy), 32'h0);
        saw = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) saw = 1'b1;
        end
        check("flush_no_done", 32'(saw), 32'h0);
        check("flush_result", result, 32'h0000_0001);

        // reset 20 cycles into an operation
        @(posedge clk); #1;
        issue(3'b100, 32'd100, 32'd7);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (19) begin @(posedge clk); #1; end
        reset_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'h0);
        check("abort_done", 32'(done), 32'h0);
        check("abort_result", result, 32'h0);
        @(posedge clk); #1;
        reset_n = 1'b1;

        // randomized operations, some back-to-back
        for (int i = 0; i < 60; i++) begin
            logic [2:0]  f;
            logic [31:0] a, b;
            f = 3'($urandom_range(0, 7));
            a = pick();
            b = pick();
            if (i == 0 || $urandom_range(0, 2) != 0) begin
                @(posedge clk); #1;
            end
            issue(f, a, b);
            wait_done("rnd", ref_op(f, a, b), 0);
        end

        repeat (5) @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
